line_buffer_write_ctrl: RTL and testbench

LINE_BUFFER_WRITE_CTRL -- requirements
Module: line_buffer_write_ctrl

---
 rtl/line_buffer_write_ctrl.sv | 127 ++++++++++++
 tb/tb_line_buffer_write_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_write_ctrl.sv
// Write-side controller for a 15-entry read register bank.
// Accepts one frame of pixels, writes them round-robin via a one-hot select,
// and tracks how many entries are still unread by a group-of-3 reader.
module line_buffer_write_ctrl #(
  parameter int DATA_W    = 8,
  parameter int FRAME_PIX = 225
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [14:0]       wr_sel,
  output logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic              grp_avail,
  output logic [3:0]        level,
  output logic              busy,
  output logic              done,
  output logic              rd_err
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Count value held just before the accept that completes the frame.
  localparam logic [7:0] LAST_PIX = 8'(FRAME_PIX - 1);

  state_t      state_q, state_d;
  logic [14:0] wr_sel_q, wr_sel_d;
  logic [3:0]  level_q, level_d;
  logic [7:0]  pix_cnt_q, pix_cnt_d;
  logic        rd_err_q, rd_err_d;

  logic        accept;
  logic        rd_ok;

  // A read is only meaningful when a full group of three is present.
  assign grp_avail = (level_q >= 4'd3);
  assign rd_ok     = rd_en && grp_avail;

  // Back-pressure never looks at rd_en, so a full bank stalls for a cycle
  // even if the reader frees space in the same cycle.
  assign in_ready  = (state_q == ST_ACTIVE) && (level_q != 4'd15);
  assign accept    = in_valid && in_ready;

  assign wr_en     = accept;
  assign wr_data   = in_data;
  assign wr_sel    = wr_sel_q;
  assign level     = level_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign rd_err    = rd_err_q;

  // Frame sequencing and pixel counting.
  always_comb begin
    state_d   = state_q;
    pix_cnt_d = pix_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_ACTIVE;
          pix_cnt_d = 8'd0;
        end
      end
      ST_ACTIVE: begin
        if (accept) begin
          pix_cnt_d = pix_cnt_q + 8'd1;
          if (pix_cnt_q == LAST_PIX) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (level_q == 4'd0) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Occupancy, write pointer rotation and sticky underflow detection.
  always_comb begin
    level_d  = level_q;
    wr_sel_d = wr_sel_q;
    rd_err_d = rd_err_q | (rd_en & ~grp_avail);
    case ({accept, rd_ok})
      2'b10:   level_d = level_q + 4'd1;
      2'b01:   level_d = level_q - 4'd3;
      2'b11:   level_d = level_q - 4'd2;
      default: level_d = level_q;
    endcase
    if (accept) begin
      wr_sel_d = {wr_sel_q[13:0], wr_sel_q[14]};
    end
  end

  // State registers; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_sel_q  <= 15'h0001;
      level_q   <= 4'd0;
      pix_cnt_q <= 8'd0;
      rd_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_sel_q  <= wr_sel_d;
      level_q   <= level_d;
      pix_cnt_q <= pix_cnt_d;
      rd_err_q  <= rd_err_d;
    end
  end

endmodule

// File: tb/tb_line_buffer_write_ctrl.sv
// Directed bench for line_buffer_write_ctrl: inputs change on the falling
// edge, outputs are sampled 1 time unit later, state advances on rising edge.
module tb_line_buffer_write_ctrl;

  localparam int DATA_W    = 8;
  localparam int FRAME_PIX = 225;

  logic              clk;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              wr_en;
  logic [14:0]       wr_sel;
  logic [DATA_W-1:0] wr_data;
  logic              rd_en;
  logic              grp_avail;
  logic [3:0]        level;
  logic              busy;
  logic              done;
  logic              rd_err;

  int checks = 0;
  int errors = 0;

  // Reference state for the frame-running loop.
  int          ph;
  int          fa;
  int          lvl;
  logic [14:0] ptr;

  line_buffer_write_ctrl #(
    .DATA_W   (DATA_W),
    .FRAME_PIX(FRAME_PIX)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_data  (wr_data),
    .rd_en    (rd_en),
    .grp_avail(grp_avail),
    .level    (level),
    .busy     (busy),
    .done     (done),
    .rd_err   (rd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      $display("check %s obs=%0h", tag, obs);
    end else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One accepted pixel: check the zero-latency write port, then step a cycle.
  task automatic push(input logic [7:0] d, input logic [14:0] sel);
    in_valid = 1'b1;
    in_data  = d;
    #1;
    chk("push_wr_en", 32'(wr_en), 32'd1);
    chk("push_wr_sel", 32'(wr_sel), 32'(sel));
    chk("push_wr_data", 32'(wr_data), 32'(d));
    @(negedge clk);
    in_valid = 1'b0;
    rd_en    = 1'b0;
    #1;
  endtask

  // Feed pixels continuously with a reader that drains whenever a group is
  // available, until the frame returns to idle. ph: 0 idle,1 active,2 drain,3 done.
  task automatic run_frame(output int dcnt, output int mm, output int fin);
    int  nph;
    bit  exp_acc;
    bit  rd_ok;
    dcnt = 0;
    mm   = 0;
    fin  = 0;
    for (int c = 0; c < 3000 && fin == 0; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'($urandom_range(0, 255));
      rd_en    = grp_avail;
      #1;
      exp_acc = (ph == 1) && (lvl < 15);
      rd_ok   = rd_en && (lvl >= 3);
      if (level !== 4'(lvl) || grp_avail !== (lvl >= 3) || in_ready !== exp_acc ||
          busy !== (ph != 0) || done !== (ph == 3) || wr_en !== exp_acc) mm++;
      if (exp_acc && (wr_sel !== ptr || wr_data !== in_data)) mm++;
      if (done === 1'b1) dcnt++;
      if (ph == 0) fin = 1;
      nph = ph;
      if (ph == 1 && exp_acc && fa + 1 == FRAME_PIX) nph = 2;
      if (ph == 2 && lvl == 0) nph = 3;
      if (ph == 3) nph = 0;
      if (exp_acc) begin
        fa++;
        ptr = {ptr[13:0], ptr[14]};
      end
      lvl = lvl + (exp_acc ? 1 : 0) - (rd_ok ? 3 : 0);
      ph  = nph;
    end
    in_valid = 1'b0;
    rd_en    = 1'b0;
  endtask

  initial begin
    int dcnt;
    int mm;
    int fin;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    rd_en    = 1'b0;

    // Reset values.
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_wr_sel", 32'(wr_sel), 32'h0001);
    chk("rst_rd_err", 32'(rd_err), 32'd0);
    chk("rst_grp_avail", 32'(grp_avail), 32'd0);
    rst = 1'b0;

    // Start and three pixels.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_in_ready", 32'(in_ready), 32'd1);
    push(8'h11, 15'h0001);
    push(8'h22, 15'h0002);
    push(8'h33, 15'h0004);
    chk("three_level", 32'(level), 32'd3);
    chk("three_grp_avail", 32'(grp_avail), 32'd1);

    // Level 4, then accept and read together: 4 + 1 - 3 = 2.
    push(8'h44, 15'h0008);
    chk("four_level", 32'(level), 32'd4);
    rd_en = 1'b1;
    push(8'h55, 15'h0010);
    chk("acc_rd_level", 32'(level), 32'd2);
    chk("acc_rd_grp_avail", 32'(grp_avail), 32'd0);

    // Underflow read with level 2.
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    #1;
    chk("uflow_level", 32'(level), 32'd2);
    chk("uflow_rd_err", 32'(rd_err), 32'd1);

    // Finish this frame with a live reader: 5 accepts so far, pointer at bit 5.
    ph  = 1;
    fa  = 5;
    lvl = 2;
    ptr = 15'h0020;
    run_frame(dcnt, mm, fin);
    chk("frame1_finished", 32'(fin), 32'd1);
    chk("frame1_model", 32'(mm), 32'd0);
    chk("frame1_done_pulses", 32'(dcnt), 32'd1);
    chk("frame1_busy", 32'(busy), 32'd0);
    chk("frame1_level", 32'(level), 32'd0);
    chk("frame1_wr_sel", 32'(wr_sel), 32'h0001);
    chk("frame1_rd_err", 32'(rd_err), 32'd1);

    // Later frame: rd_err still set; 7 pixels with no reader.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("frame2_busy", 32'(busy), 32'd1);
    chk("frame2_rd_err", 32'(rd_err), 32'd1);
    in_valid = 1'b1;
    repeat (7) @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("frame2_level", 32'(level), 32'd7);
    chk("frame2_wr_sel", 32'(wr_sel), 32'h0080);

    // Mid-frame reset overrides start, in_valid and rd_en.
    @(negedge clk);
    rst      = 1'b1;
    start    = 1'b1;
    in_valid = 1'b1;
    rd_en    = 1'b1;
    @(negedge clk);
    rst      = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    rd_en    = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_level", 32'(level), 32'd0);
    chk("mid_rst_wr_sel", 32'(wr_sel), 32'h0001);
    chk("mid_rst_rd_err", 32'(rd_err), 32'd0);

    // New frame: fill all 15 entries, 16th stalls, pointer wraps.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      in_data = 8'(i + 8'hA0);
      #1;
      chk("fill_wr_en", 32'(wr_en), 32'd1);
      chk("fill_wr_sel", 32'(wr_sel), 32'(15'h0001 << i));
      @(negedge clk);
    end
    #1;
    chk("full_level", 32'(level), 32'd15);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_stall_wr_en", 32'(wr_en), 32'd0);
    chk("full_wr_sel_wrap", 32'(wr_sel), 32'h0001);
    chk("full_grp_avail", 32'(grp_avail), 32'd1);

    // Complete that frame normally.
    ph  = 1;
    fa  = 15;
    lvl = 15;
    ptr = 15'h0001;
    run_frame(dcnt, mm, fin);
    chk("frame3_finished", 32'(fin), 32'd1);
    chk("frame3_model", 32'(mm), 32'd0);
    chk("frame3_done_pulses", 32'(dcnt), 32'd1);
    chk("frame3_busy", 32'(busy), 32'd0);
    chk("frame3_rd_err", 32'(rd_err), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
